riscv_v_lmul_sequencer: RTL and testbench



---
 rtl/riscv_v_lmul_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_riscv_v_lmul_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_v_lmul_sequencer.sv
// rtl/riscv_v_lmul_sequencer.sv - vector register-group sequencer between ID and EXE
//
// Purpose: accepts one decoded vector instruction with its LMUL/SEW/vl/vstart
// context and expands it into one micro-op per register of the group. Each
// micro-op carries per-byte write enables. The front end is stalled while the
// group is issued.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   clear_pipe             synchronous flush; abandons any group in flight
//   riscv_stall            freezes the sequencer (outputs, idx, state held)
//   issue_valid            decoded vector instruction present
//   issue_vd/vs1/vs2       base register addresses
//   issue_lmul             vlmul encoding (0..3 -> 1,2,4,8; 4..7 -> 1)
//   issue_sew              element width (0..3 -> 8,16,32,64 bits)
//   issue_vl/issue_vstart  element counts
//   busy                   cannot accept a new instruction
//   uop_valid              micro-op valid
//   uop_vd/vs1/vs2         per-uop register addresses
//   uop_idx                position of the uop inside its group
//   uop_last               final uop of the group
//   uop_byte_en            per-byte write enable
//   illegal                one-cycle pulse on a misaligned register group
module riscv_v_lmul_sequencer #(
  parameter int VLEN       = 128,
  parameter int ADDR_WIDTH = 5,
  parameter int MAX_LMUL   = 8,
  localparam int NUM_BYTES = VLEN / 8,
  localparam int VL_WIDTH  = $clog2(NUM_BYTES * MAX_LMUL) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_pipe,
  input  logic                  riscv_stall,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_vd,
  input  logic [ADDR_WIDTH-1:0] issue_vs1,
  input  logic [ADDR_WIDTH-1:0] issue_vs2,
  input  logic [2:0]            issue_lmul,
  input  logic [1:0]            issue_sew,
  input  logic [VL_WIDTH-1:0]   issue_vl,
  input  logic [VL_WIDTH-1:0]   issue_vstart,
  output logic                  busy,
  output logic                  uop_valid,
  output logic [ADDR_WIDTH-1:0] uop_vd,
  output logic [ADDR_WIDTH-1:0] uop_vs1,
  output logic [ADDR_WIDTH-1:0] uop_vs2,
  output logic [2:0]            uop_idx,
  output logic                  uop_last,
  output logic [NUM_BYTES-1:0]  uop_byte_en,
  output logic                  illegal
);

  typedef enum logic {IDLE, SEQ} state_t;

  localparam logic [1:0]            LMUL_LOG2_MAX = 2'($clog2(MAX_LMUL));
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE      = ADDR_WIDTH'(1);

  state_t                state_q;
  logic [2:0]            idx_q;
  logic [2:0]            gm1_q;      // group size minus one
  logic [1:0]            sew_q;
  logic [VL_WIDTH-1:0]   vl_q;       // effective (clamped) vl
  logic [VL_WIDTH-1:0]   vstart_q;
  logic                  uop_valid_q;
  logic [ADDR_WIDTH-1:0] uop_vd_q;
  logic [ADDR_WIDTH-1:0] uop_vs1_q;
  logic [ADDR_WIDTH-1:0] uop_vs2_q;
  logic                  uop_last_q;
  logic [NUM_BYTES-1:0]  uop_byte_en_q;
  logic                  illegal_q;

  logic [1:0]            lmul_log2_d;
  logic [2:0]            gm1_d;
  logic [VL_WIDTH-1:0]   vlmax_d;
  logic [VL_WIDTH-1:0]   vl_eff_d;
  logic [ADDR_WIDTH-1:0] align_mask_d;
  logic                  misaligned_d;
  logic                  empty_d;
  logic                  accept_d;
  logic [2:0]            idx_d;
  logic [NUM_BYTES-1:0]  be_first_d;
  logic [NUM_BYTES-1:0]  be_next_d;

  // Element index of byte b in register idx is idx*EPR + (b >> sew).
  function automatic logic [NUM_BYTES-1:0] calc_byte_en(
    input logic [2:0]          idx,
    input logic [1:0]          sew,
    input logic [VL_WIDTH-1:0] vl,
    input logic [VL_WIDTH-1:0] vstart
  );
    logic [NUM_BYTES-1:0] en;
    logic [VL_WIDTH-1:0]  epr;
    logic [VL_WIDTH-1:0]  e;
    en  = '0;
    epr = VL_WIDTH'(NUM_BYTES) >> sew;
    for (int b = 0; b < NUM_BYTES; b++) begin
      e     = VL_WIDTH'(VL_WIDTH'(idx) * epr) + (VL_WIDTH'(b) >> sew);
      en[b] = (e >= vstart) && (e < vl);
    end
    return en;
  endfunction

  always_comb begin
    // Fractional LMUL behaves as a single register; also never exceed MAX_LMUL.
    lmul_log2_d = issue_lmul[2] ? 2'd0 : issue_lmul[1:0];
    if (lmul_log2_d > LMUL_LOG2_MAX) lmul_log2_d = LMUL_LOG2_MAX;
    gm1_d        = 3'((4'd1 << lmul_log2_d) - 4'd1);
    vlmax_d      = (VL_WIDTH'(NUM_BYTES) >> issue_sew) << lmul_log2_d;
    vl_eff_d     = (issue_vl < vlmax_d) ? issue_vl : vlmax_d;
    align_mask_d = ADDR_WIDTH'(gm1_d);
    misaligned_d = |((issue_vd | issue_vs1 | issue_vs2) & align_mask_d);
    empty_d      = issue_vstart >= vl_eff_d;
    idx_d        = idx_q + 3'd1;
    be_first_d   = calc_byte_en(3'd0, issue_sew, vl_eff_d, issue_vstart);
    be_next_d    = calc_byte_en(idx_d, sew_q, vl_q, vstart_q);
  end

  // Dropping busy during the last uop lets the next group start without a bubble.
  assign busy     = (state_q == SEQ) && !uop_last_q;
  assign accept_d = issue_valid && !busy && !riscv_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      gm1_q         <= '0;
      sew_q         <= '0;
      vl_q          <= '0;
      vstart_q      <= '0;
      uop_valid_q   <= 1'b0;
      uop_vd_q      <= '0;
      uop_vs1_q     <= '0;
      uop_vs2_q     <= '0;
      uop_last_q    <= 1'b0;
      uop_byte_en_q <= '0;
      illegal_q     <= 1'b0;
    end else if (clear_pipe) begin
      state_q     <= IDLE;
      uop_valid_q <= 1'b0;
      uop_last_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else if (riscv_stall) begin
      // Everything is frozen; illegal stays a single-cycle pulse.
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      if (accept_d) begin
        if (misaligned_d) begin
          state_q     <= IDLE;
          uop_valid_q <= 1'b0;
          uop_last_q  <= 1'b0;
          illegal_q   <= 1'b1;
        end else if (empty_d) begin
          state_q     <= IDLE;
          uop_valid_q <= 1'b0;
          uop_last_q  <= 1'b0;
        end else begin
          state_q       <= SEQ;
          idx_q         <= 3'd0;
          gm1_q         <= gm1_d;
          sew_q         <= issue_sew;
          vl_q          <= vl_eff_d;
          vstart_q      <= issue_vstart;
          uop_valid_q   <= 1'b1;
          uop_vd_q      <= issue_vd;
          uop_vs1_q     <= issue_vs1;
          uop_vs2_q     <= issue_vs2;
          uop_last_q    <= (gm1_d == 3'd0);
          uop_byte_en_q <= be_first_d;
        end
      end else if (state_q == SEQ) begin
        if (!uop_last_q) begin
          // Group is aligned, so base + idx never carries out of the group.
          idx_q         <= idx_d;
          uop_vd_q      <= uop_vd_q + ADDR_ONE;
          uop_vs1_q     <= uop_vs1_q + ADDR_ONE;
          uop_vs2_q     <= uop_vs2_q + ADDR_ONE;
          uop_last_q    <= (idx_d == gm1_q);
          uop_byte_en_q <= be_next_d;
        end else begin
          state_q     <= IDLE;
          uop_valid_q <= 1'b0;
          uop_last_q  <= 1'b0;
        end
      end
    end
  end

  assign uop_valid   = uop_valid_q;
  assign uop_vd      = uop_vd_q;
  assign uop_vs1     = uop_vs1_q;
  assign uop_vs2     = uop_vs2_q;
  assign uop_idx     = idx_q;
  assign uop_last    = uop_last_q;
  assign uop_byte_en = uop_byte_en_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_riscv_v_lmul_sequencer.sv
// tb/tb_riscv_v_lmul_sequencer.sv - self-checking bench for riscv_v_lmul_sequencer
module tb_riscv_v_lmul_sequencer;

  localparam int AW = 5;
  localparam int NB = 16;
  localparam int VW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_pipe;
  logic          riscv_stall;
  logic          issue_valid;
  logic [AW-1:0] issue_vd, issue_vs1, issue_vs2;
  logic [2:0]    issue_lmul;
  logic [1:0]    issue_sew;
  logic [VW-1:0] issue_vl, issue_vstart;
  logic          busy, uop_valid, uop_last, illegal;
  logic [AW-1:0] uop_vd, uop_vs1, uop_vs2;
  logic [2:0]    uop_idx;
  logic [NB-1:0] uop_byte_en;

  int checks = 0;
  int errors = 0;

  riscv_v_lmul_sequencer #(.VLEN(128), .ADDR_WIDTH(AW), .MAX_LMUL(8)) dut (
    .clk(clk), .rst(rst), .clear_pipe(clear_pipe), .riscv_stall(riscv_stall),
    .issue_valid(issue_valid), .issue_vd(issue_vd), .issue_vs1(issue_vs1),
    .issue_vs2(issue_vs2), .issue_lmul(issue_lmul), .issue_sew(issue_sew),
    .issue_vl(issue_vl), .issue_vstart(issue_vstart), .busy(busy),
    .uop_valid(uop_valid), .uop_vd(uop_vd), .uop_vs1(uop_vs1), .uop_vs2(uop_vs2),
    .uop_idx(uop_idx), .uop_last(uop_last), .uop_byte_en(uop_byte_en),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]          lmul;
    logic [1:0]          sew;
    logic [7:0]          vl;
    logic [7:0]          vstart;
    logic [4:0]          vd;
    logic [4:0]          vs1;
    logic [4:0]          vs2;
    logic                ill;
    logic [3:0]          n;
    logic [7:0][15:0]    be;   // be[i] is the expected byte enable of uop i
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic [2:0] lmul, input logic [1:0] sew,
                           input logic [7:0] vl, input logic [7:0] vstart,
                           input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
    issue_lmul   = lmul;
    issue_sew    = sew;
    issue_vl     = vl;
    issue_vstart = vstart;
    issue_vd     = vd;
    issue_vs1    = vs1;
    issue_vs2    = vs2;
    issue_valid  = 1'b1;
  endtask

  function automatic vec_t mk(input logic [2:0] lmul, input logic [1:0] sew,
                              input logic [7:0] vl, input logic [7:0] vstart,
                              input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2,
                              input logic ill, input logic [3:0] n, input logic [127:0] be);
    vec_t t;
    t.lmul = lmul; t.sew = sew; t.vl = vl; t.vstart = vstart;
    t.vd = vd; t.vs1 = vs1; t.vs2 = vs2; t.ill = ill; t.n = n; t.be = be;
    return t;
  endfunction

  int consumed;

  initial begin
    // Expected byte enables are listed last-uop-first inside each concatenation.
    vecs[0] = mk(3'd0, 2'd0, 8'd16, 8'd0, 5'd3, 5'd5, 5'd7, 1'b0, 4'd1,
                 {112'h0, 16'hFFFF});
    vecs[1] = mk(3'd2, 2'd2, 8'd10, 8'd0, 5'd8, 5'd12, 5'd4, 1'b0, 4'd4,
                 {64'h0, 16'h0000, 16'h00FF, 16'hFFFF, 16'hFFFF});
    vecs[2] = mk(3'd1, 2'd1, 8'd40, 8'd5, 5'd2, 5'd4, 5'd6, 1'b0, 4'd2,
                 {96'h0, 16'hFFFF, 16'hFC00});
    vecs[3] = mk(3'd3, 2'd0, 8'd16, 8'd0, 5'd4, 5'd0, 5'd8, 1'b1, 4'd0, 128'h0);
    vecs[4] = mk(3'd0, 2'd0, 8'd3, 8'd3, 5'd1, 5'd2, 5'd3, 1'b0, 4'd0, 128'h0);
    vecs[5] = mk(3'd5, 2'd3, 8'd1, 8'd0, 5'd1, 5'd3, 5'd5, 1'b0, 4'd1,
                 {112'h0, 16'h00FF});
    vecs[6] = mk(3'd3, 2'd3, 8'd7, 8'd3, 5'd8, 5'd16, 5'd24, 1'b0, 4'd8,
                 {16'h0, 16'h0, 16'h0, 16'h0, 16'h00FF, 16'hFFFF, 16'hFF00, 16'h0000});
    vecs[7] = mk(3'd1, 2'd0, 8'd16, 8'd0, 5'd2, 5'd4, 5'd5, 1'b1, 4'd0, 128'h0);

    rst = 1'b1; clear_pipe = 1'b0; riscv_stall = 1'b0; issue_valid = 1'b0;
    issue_vd = '0; issue_vs1 = '0; issue_vs2 = '0; issue_lmul = '0; issue_sew = '0;
    issue_vl = '0; issue_vstart = '0;
    tick(); tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(uop_valid), 32'd0);
    chk("reset_addr", 32'({uop_vd, uop_vs1, uop_vs2}), 32'd0);
    chk("reset_idx_last", 32'({uop_idx, uop_last}), 32'd0);
    chk("reset_be", 32'(uop_byte_en), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      set_issue(vecs[v].lmul, vecs[v].sew, vecs[v].vl, vecs[v].vstart,
                vecs[v].vd, vecs[v].vs1, vecs[v].vs2);
      tick();
      issue_valid = 1'b0;
      if (vecs[v].ill) begin
        chk($sformatf("v%0d_illegal", v), 32'(illegal), 32'd1);
        chk($sformatf("v%0d_ill_novalid", v), 32'(uop_valid), 32'd0);
        tick();
        chk($sformatf("v%0d_illegal_pulse", v), 32'(illegal), 32'd0);
        chk($sformatf("v%0d_ill_novalid2", v), 32'(uop_valid), 32'd0);
      end else if (vecs[v].n == 0) begin
        chk($sformatf("v%0d_empty_noill", v), 32'(illegal), 32'd0);
        chk($sformatf("v%0d_empty_novalid", v), 32'(uop_valid), 32'd0);
        tick();
        chk($sformatf("v%0d_empty_novalid2", v), 32'(uop_valid), 32'd0);
      end else begin
        for (int i = 0; i < int'(vecs[v].n); i++) begin
          if (i > 0) tick();
          chk($sformatf("v%0d_u%0d_valid", v, i), 32'(uop_valid), 32'd1);
          chk($sformatf("v%0d_u%0d_idx", v, i), 32'(uop_idx), 32'(i));
          chk($sformatf("v%0d_u%0d_vd", v, i), 32'(uop_vd), 32'(vecs[v].vd) + 32'(i));
          chk($sformatf("v%0d_u%0d_vs1", v, i), 32'(uop_vs1), 32'(vecs[v].vs1) + 32'(i));
          chk($sformatf("v%0d_u%0d_vs2", v, i), 32'(uop_vs2), 32'(vecs[v].vs2) + 32'(i));
          chk($sformatf("v%0d_u%0d_last", v, i), 32'(uop_last), 32'(i == int'(vecs[v].n) - 1));
          chk($sformatf("v%0d_u%0d_busy", v, i), 32'(busy), 32'(i != int'(vecs[v].n) - 1));
          chk($sformatf("v%0d_u%0d_be", v, i), 32'(uop_byte_en), 32'(vecs[v].be[i]));
          chk($sformatf("v%0d_u%0d_noill", v, i), 32'(illegal), 32'd0);
        end
        tick();
        chk($sformatf("v%0d_end_valid", v), 32'(uop_valid), 32'd0);
        chk($sformatf("v%0d_end_busy", v), 32'(busy), 32'd0);
      end
      tick();
    end

    // Stall mid-group: idx 1 held for 4 cycles, exactly 4 uops consumed.
    consumed = 0;
    set_issue(3'd2, 2'd0, 8'd64, 8'd0, 5'd0, 5'd4, 5'd8);
    tick();
    issue_valid = 1'b0;
    chk("stall_u0_idx", 32'(uop_idx), 32'd0);
    if (uop_valid && !riscv_stall) consumed++;
    tick();
    chk("stall_u1_idx", 32'(uop_idx), 32'd1);
    riscv_stall = 1'b1;
    for (int s = 0; s < 3; s++) begin
      if (uop_valid && !riscv_stall) consumed++;
      tick();
      chk($sformatf("stall_hold%0d_idx", s), 32'(uop_idx), 32'd1);
      chk($sformatf("stall_hold%0d_vd", s), 32'(uop_vd), 32'd1);
      chk($sformatf("stall_hold%0d_valid", s), 32'(uop_valid), 32'd1);
      chk($sformatf("stall_hold%0d_be", s), 32'(uop_byte_en), 32'hFFFF);
      chk($sformatf("stall_hold%0d_busy", s), 32'(busy), 32'd1);
    end
    riscv_stall = 1'b0;
    if (uop_valid && !riscv_stall) consumed++;
    tick();
    chk("stall_u2_idx", 32'(uop_idx), 32'd2);
    if (uop_valid && !riscv_stall) consumed++;
    tick();
    chk("stall_u3_idx", 32'(uop_idx), 32'd3);
    chk("stall_u3_last", 32'(uop_last), 32'd1);
    if (uop_valid && !riscv_stall) consumed++;
    tick();
    chk("stall_done_valid", 32'(uop_valid), 32'd0);
    chk("stall_uop_count", 32'(consumed), 32'd4);
    tick();

    // Flush during idx 1 of 4: nothing more emitted afterwards.
    set_issue(3'd2, 2'd0, 8'd64, 8'd0, 5'd4, 5'd8, 5'd12);
    tick();
    issue_valid = 1'b0;
    tick();
    chk("flush_pre_idx", 32'(uop_idx), 32'd1);
    clear_pipe = 1'b1;
    tick();
    clear_pipe = 1'b0;
    chk("flush_valid", 32'(uop_valid), 32'd0);
    chk("flush_busy", 32'(busy), 32'd0);
    tick();
    chk("flush_no_partial", 32'(uop_valid), 32'd0);

    // Instruction presented together with clear_pipe is discarded.
    set_issue(3'd0, 2'd0, 8'd16, 8'd0, 5'd1, 5'd2, 5'd3);
    clear_pipe = 1'b1;
    tick();
    clear_pipe = 1'b0;
    issue_valid = 1'b0;
    chk("flush_discard_valid", 32'(uop_valid), 32'd0);
    tick();
    chk("flush_discard_valid2", 32'(uop_valid), 32'd0);

    // Back-to-back: new issue during uop_last starts with no bubble.
    set_issue(3'd1, 2'd0, 8'd32, 8'd0, 5'd0, 5'd2, 5'd4);
    tick();
    issue_valid = 1'b0;
    chk("b2b_g0_u0_idx", 32'(uop_idx), 32'd0);
    tick();
    chk("b2b_g0_u1_last", 32'(uop_last), 32'd1);
    chk("b2b_g0_u1_busy", 32'(busy), 32'd0);
    set_issue(3'd0, 2'd0, 8'd16, 8'd0, 5'd9, 5'd10, 5'd11);
    tick();
    issue_valid = 1'b0;
    chk("b2b_g1_valid", 32'(uop_valid), 32'd1);
    chk("b2b_g1_vd", 32'(uop_vd), 32'd9);
    chk("b2b_g1_vs1", 32'(uop_vs1), 32'd10);
    chk("b2b_g1_idx_last", 32'({uop_idx, uop_last}), 32'b0001);
    tick();
    chk("b2b_end_valid", 32'(uop_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
